// File: rtl/health_damage_arbiter_if.sv
// Damage/health bus between collision logic (master) and health_damage_arbiter (slave).
// heal_req exists only when HEALTH_HEAL_EN is defined.
interface health_damage_arbiter_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]   dmg_req;
  logic [2*N_SRC-1:0] dmg_amt;
  logic [N_SRC-1:0]   dmg_grant;
  logic [3:0]         health;
  logic               invuln;
  logic               dead;
  logic               hit_pulse;
`ifdef HEALTH_HEAL_EN
  logic               heal_req;
`endif

  modport master (
    output dmg_req,
    output dmg_amt,
`ifdef HEALTH_HEAL_EN
    output heal_req,
`endif
    input  dmg_grant,
    input  health,
    input  invuln,
    input  dead,
    input  hit_pulse
  );

  modport slave (
    input  dmg_req,
    input  dmg_amt,
`ifdef HEALTH_HEAL_EN
    input  heal_req,
`endif
    output dmg_grant,
    output health,
    output invuln,
    output dead,
    output hit_pulse
  );
endinterface

// File: rtl/health_damage_arbiter.sv
// Player health sequencer: round-robin damage arbitration, invulnerability window,
// death hold-off and auto-respawn. Optional heal pickup via `define HEALTH_HEAL_EN.
module health_damage_arbiter #(
  parameter int N_SRC          = 4,
  parameter int HEALTH_MAX     = 8,
  parameter int INVULN_CYCLES  = 300,
  parameter int RESPAWN_CYCLES = 200
) (
  input logic                    clk,
  input logic                    reset_n,
  health_damage_arbiter_if.slave bus
);

  localparam int IW   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int TMAX = (INVULN_CYCLES > RESPAWN_CYCLES) ? INVULN_CYCLES : RESPAWN_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [3:0]    HMAX      = 4'(HEALTH_MAX);
  localparam logic [TW-1:0] T_INVULN  = TW'(INVULN_CYCLES - 1);
  localparam logic [TW-1:0] T_RESPAWN = TW'(RESPAWN_CYCLES - 1);
  localparam logic [IW-1:0] LAST_SRC  = IW'(N_SRC - 1);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  // First set request bit at or above ptr, wrapping at N_SRC.
  function automatic logic [IW-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                            input logic [IW-1:0]    ptr);
    logic [IW-1:0] win;
    logic          found;
    int            idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(ptr) + k) % N_SRC;
      if (!found && req[idx]) begin
        win   = IW'(idx);
        found = 1'b1;
      end else begin
        win   = win;
        found = found;
      end
    end
    return win;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [TW-1:0]    timer_r, timer_nxt_s;
  logic [IW-1:0]    rr_r, rr_nxt_s;
  logic [3:0]       health_r, health_nxt_s;
  logic [N_SRC-1:0] grant_r, grant_nxt_s;
  logic             hit_r, hit_nxt_s;
  logic             invuln_r, dead_r;

  logic [IW-1:0]    win_s;
  logic [1:0]       amt_raw_s;
  logic [3:0]       dmg_s;
  logic [3:0]       heal_health_s;
  logic             heal_s;

`ifdef HEALTH_HEAL_EN
  assign heal_s = bus.heal_req;
`else
  assign heal_s = 1'b0;
`endif

  assign win_s         = rr_pick(bus.dmg_req, rr_r);
  assign amt_raw_s     = bus.dmg_amt[{win_s, 1'b0} +: 2];
  // An encoded amount of 0 still costs one point.
  assign dmg_s         = (amt_raw_s == 2'd0) ? 4'd1 : {2'b00, amt_raw_s};
  assign heal_health_s = (health_r < HMAX) ? (health_r + 4'd1) : HMAX;

  // Next-state, timer, health and pulse computation.
  always_comb begin
    state_nxt_s  = state_r;
    timer_nxt_s  = timer_r;
    rr_nxt_s     = rr_r;
    health_nxt_s = health_r;
    grant_nxt_s  = {N_SRC{1'b0}};
    hit_nxt_s    = 1'b0;
    case (state_r)
      ST_ALIVE: begin
        if (|bus.dmg_req) begin
          grant_nxt_s = {{(N_SRC-1){1'b0}}, 1'b1} << win_s;
          hit_nxt_s   = 1'b1;
          rr_nxt_s    = (win_s == LAST_SRC) ? {IW{1'b0}} : (win_s + IW'(1));
          // Saturate at zero; the hit always wins over a same-cycle heal.
          if (health_r <= dmg_s) begin
            health_nxt_s = 4'd0;
            state_nxt_s  = ST_DEAD;
            timer_nxt_s  = T_RESPAWN;
          end else begin
            health_nxt_s = health_r - dmg_s;
            state_nxt_s  = ST_INVULN;
            timer_nxt_s  = T_INVULN;
          end
        end else if (heal_s) begin
          health_nxt_s = heal_health_s;
        end else begin
          health_nxt_s = health_r;
        end
      end
      ST_INVULN: begin
        if (heal_s) begin
          health_nxt_s = heal_health_s;
        end else begin
          health_nxt_s = health_r;
        end
        if (timer_r == {TW{1'b0}}) begin
          state_nxt_s = ST_ALIVE;
        end else begin
          timer_nxt_s = timer_r - TW'(1);
        end
      end
      ST_DEAD: begin
        if (timer_r == {TW{1'b0}}) begin
          state_nxt_s  = ST_ALIVE;
          health_nxt_s = HMAX;
        end else begin
          timer_nxt_s  = timer_r - TW'(1);
        end
      end
      default: begin
        state_nxt_s  = ST_ALIVE;
        timer_nxt_s  = {TW{1'b0}};
        health_nxt_s = HMAX;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_ALIVE;
      timer_r  <= {TW{1'b0}};
      rr_r     <= {IW{1'b0}};
      health_r <= HMAX;
      grant_r  <= {N_SRC{1'b0}};
      hit_r    <= 1'b0;
      invuln_r <= 1'b0;
      dead_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      timer_r  <= timer_nxt_s;
      rr_r     <= rr_nxt_s;
      health_r <= health_nxt_s;
      grant_r  <= grant_nxt_s;
      hit_r    <= hit_nxt_s;
      invuln_r <= (state_nxt_s == ST_INVULN);
      dead_r   <= (state_nxt_s == ST_DEAD);
    end
  end

  assign bus.dmg_grant = grant_r;
  assign bus.health    = health_r;
  assign bus.invuln    = invuln_r;
  assign bus.dead      = dead_r;
  assign bus.hit_pulse = hit_r;

endmodule

// File: tb/tb_health_damage_arbiter.sv
// Scoreboard bench for health_damage_arbiter (N_SRC=4, HEALTH_MAX=8, INVULN=5, RESPAWN=3).
// Heal scenario is compiled only with HEALTH_HEAL_EN.
module tb_health_damage_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  health_damage_arbiter_if #(.N_SRC(N)) bus ();

  health_damage_arbiter #(
    .N_SRC(N), .HEALTH_MAX(8), .INVULN_CYCLES(5), .RESPAWN_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  typedef struct {
    logic [3:0] grant;
    logic [3:0] health;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Every accepted hit must match the oldest expected grant/health.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.hit_pulse === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_hit: grant=%b health=%0d, no hit expected", bus.dmg_grant, bus.health);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.dmg_grant !== mon_e.grant || bus.health !== mon_e.health) begin
          errors++;
          $display("FAIL sb_hit: grant=%b health=%0d, expected grant=%b health=%0d",
                   bus.dmg_grant, bus.health, mon_e.grant, mon_e.health);
        end
      end
    end else if (reset_n === 1'b1 && bus.dmg_grant !== 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL grant_without_hit: grant=%b hit_pulse=%b", bus.dmg_grant, bus.hit_pulse);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    reset_n = 1'b0;
    bus.dmg_req = 4'b0000;
    bus.dmg_amt = 8'h00;
`ifdef HEALTH_HEAL_EN
    bus.heal_req = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Caller sits 1 time unit after a rising edge; returns one edge later with req dropped.
  task automatic do_hit(input logic [3:0] req, input logic [7:0] amt,
                        input logic [3:0] eg, input logic [3:0] eh);
    exp_t e;
    e.grant  = eg;
    e.health = eh;
    sb_q.push_back(e);
    bus.dmg_req = req;
    bus.dmg_amt = amt;
    @(posedge clk); #1;
    bus.dmg_req = 4'b0000;
    checks++;
    if (bus.hit_pulse !== 1'b1) begin
      errors++;
      $display("FAIL hit_latency: hit_pulse=%b, expected 1 one cycle after request", bus.hit_pulse);
    end
  endtask

  task automatic wait_alive(input string tag);
    int n;
    n = 0;
    while ((bus.invuln !== 1'b0 || bus.dead !== 1'b0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.invuln !== 1'b0 || bus.dead !== 1'b0) begin
      errors++;
      $display("FAIL %s_alive: invuln=%b dead=%b, expected both 0", tag, bus.invuln, bus.dead);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.health !== 4'd8 || bus.invuln !== 1'b0 || bus.dead !== 1'b0 ||
        bus.dmg_grant !== 4'b0000 || bus.hit_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: health=%0d invuln=%b dead=%b grant=%b hit=%b, expected 8 0 0 0000 0",
               bus.health, bus.invuln, bus.dead, bus.dmg_grant, bus.hit_pulse);
    end
    do_hit(4'b0001, 8'h01, 4'b0001, 4'd7);
    @(negedge clk);
    checks++;
    if (bus.invuln !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_invuln: invuln=%b, expected 1", bus.invuln);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.health !== 4'd8 || bus.invuln !== 1'b0 || bus.dead !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: health=%0d invuln=%b dead=%b, expected 8 0 0",
               bus.health, bus.invuln, bus.dead);
    end
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.health !== 4'd8 || bus.invuln !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: health=%0d invuln=%b, expected 8 0", bus.health, bus.invuln);
    end
  endtask

  task automatic test_single_hit();
    int n;
    do_hit(4'b0001, 8'h01, 4'b0001, 4'd7);
    n = (bus.invuln === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        checks++;
        if (bus.hit_pulse !== 1'b0) begin
          errors++;
          $display("FAIL hit_width: hit_pulse=%b on 2nd cycle, expected 0", bus.hit_pulse);
        end
      end
      if (bus.invuln === 1'b1) n++;
      else break;
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL invuln_len: invuln high %0d cycles, expected 5", n);
    end
    checks++;
    if (bus.health !== 4'd7 || bus.dead !== 1'b0) begin
      errors++;
      $display("FAIL single_hit_health: health=%0d dead=%b, expected 7 0", bus.health, bus.dead);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   hits;
    int   last;
    logic [3:0] g;
    do_reset();
    g = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      e.grant  = g;
      e.health = 4'(7 - k);
      sb_q.push_back(e);
      g = {g[2:0], g[3]};
    end
    bus.dmg_req = 4'b1111;
    bus.dmg_amt = 8'h55;
    hits = 0;
    last = -1;
    for (int c = 0; c < 80 && hits < 5; c++) begin
      @(posedge clk); #1;
      if (bus.hit_pulse === 1'b1) begin
        hits++;
        if (last >= 0) begin
          checks++;
          if (c - last != 6) begin
            errors++;
            $display("FAIL rr_spacing: hit %0d came %0d cycles after previous, expected 6", hits, c - last);
          end
        end
        last = c;
      end
    end
    bus.dmg_req = 4'b0000;
    checks++;
    if (hits != 5) begin
      errors++;
      $display("FAIL rr_hits: %0d hits observed, expected 5", hits);
    end
    wait_alive("rr");
    checks++;
    if (bus.health !== 4'd3) begin
      errors++;
      $display("FAIL rr_health: health=%0d, expected 3", bus.health);
    end
  endtask

  task automatic test_death();
    int n;
    do_hit(4'b0010, 8'h55, 4'b0010, 4'd2);
    wait_alive("pre_death");
    do_hit(4'b0100, 8'h75, 4'b0100, 4'd0);
    bus.dmg_req = 4'b1011;
    checks++;
    if (bus.dead !== 1'b1 || bus.health !== 4'd0) begin
      errors++;
      $display("FAIL death_entry: dead=%b health=%0d, expected 1 0", bus.dead, bus.health);
    end
    n = (bus.dead === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.dmg_grant !== 4'b0000) begin
        errors++;
        $display("FAIL dead_grant: grant=%b while dead, expected 0000", bus.dmg_grant);
      end
      if (bus.dead === 1'b1) n++;
      else break;
    end
    bus.dmg_req = 4'b0000;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL dead_len: dead high %0d cycles, expected 3", n);
    end
    checks++;
    if (bus.health !== 4'd8 || bus.invuln !== 1'b0) begin
      errors++;
      $display("FAIL respawn: health=%0d invuln=%b, expected 8 0", bus.health, bus.invuln);
    end
  endtask

  task automatic test_invuln_ignore();
    do_hit(4'b1000, 8'h55, 4'b1000, 4'd7);
    @(posedge clk); #1;
    bus.dmg_req = 4'b0001;
    bus.dmg_amt = 8'h00;
    @(posedge clk); #1;
    bus.dmg_req = 4'b0000;
    checks++;
    if (bus.dmg_grant !== 4'b0000 || bus.hit_pulse !== 1'b0 || bus.health !== 4'd7) begin
      errors++;
      $display("FAIL invuln_ignore: grant=%b hit=%b health=%0d, expected 0000 0 7",
               bus.dmg_grant, bus.hit_pulse, bus.health);
    end
    wait_alive("ignore");
    checks++;
    if (bus.health !== 4'd7) begin
      errors++;
      $display("FAIL ignore_health: health=%0d, expected 7", bus.health);
    end
    do_hit(4'b0001, 8'h00, 4'b0001, 4'd6);
    wait_alive("amt0");
    checks++;
    if (bus.health !== 4'd6) begin
      errors++;
      $display("FAIL amt0_health: health=%0d, expected 6", bus.health);
    end
  endtask

`ifdef HEALTH_HEAL_EN
  task automatic test_heal();
    do_reset();
    bus.heal_req = 1'b1;
    @(posedge clk); #1;
    bus.heal_req = 1'b0;
    checks++;
    if (bus.health !== 4'd8) begin
      errors++;
      $display("FAIL heal_cap: health=%0d, expected 8", bus.health);
    end
    do_hit(4'b0001, 8'h03, 4'b0001, 4'd5);
    bus.heal_req = 1'b1;
    @(posedge clk); #1;
    bus.heal_req = 1'b0;
    checks++;
    if (bus.health !== 4'd6 || bus.invuln !== 1'b1) begin
      errors++;
      $display("FAIL heal_inc: health=%0d invuln=%b, expected 6 1", bus.health, bus.invuln);
    end
    wait_alive("heal");
    do_hit(4'b0001, 8'h01, 4'b0001, 4'd5);
    wait_alive("heal2");
    bus.heal_req = 1'b1;
    do_hit(4'b0001, 8'h02, 4'b0001, 4'd3);
    bus.heal_req = 1'b0;
    checks++;
    if (bus.health !== 4'd3) begin
      errors++;
      $display("FAIL heal_vs_hit: health=%0d, expected 3", bus.health);
    end
    wait_alive("heal3");
  endtask
`endif

  initial begin
    test_reset();
    test_single_hit();
    test_back_to_back();
    test_death();
    test_invuln_ignore();
`ifdef HEALTH_HEAL_EN
    test_heal();
`endif
    repeat (2) @(posedge clk); #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected hits never seen, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
